// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch front end.
package fetch_pkg;

  localparam int unsigned FETCH_W = 32;

  localparam logic [FETCH_W-1:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [FETCH_W-1:0] NOP_INSTR_DEF = 32'h0000_0000;
  localparam logic [FETCH_W-1:0] PC_INC        = 32'd4;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    KILL = 2'd2
  } fetch_state_e;

  // One buffered fetch result as presented to the decode register.
  typedef struct packed {
    logic [FETCH_W-1:0] instr;
    logic [FETCH_W-1:0] pc_plus_4;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between fetch and memory.
interface fetch_unit_if;
  import fetch_pkg::*;

  logic               IMEM_REQ;
  logic [FETCH_W-1:0] IMEM_ADDR;
  logic               IMEM_GNT;
  logic               IMEM_RVALID;
  logic [FETCH_W-1:0] IMEM_RDATA;

  modport master (
    output IMEM_REQ,
    output IMEM_ADDR,
    input  IMEM_GNT,
    input  IMEM_RVALID,
    input  IMEM_RDATA
  );

  modport slave (
    input  IMEM_REQ,
    input  IMEM_ADDR,
    output IMEM_GNT,
    output IMEM_RVALID,
    output IMEM_RDATA
  );
endinterface

// File: rtl/fetch_buffer.sv
// One-entry holding register for a fetched instruction and its PC+4.
// An empty entry reads back as NOP / 0 so the outputs come straight from flops.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter logic [FETCH_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         consume,
  input  logic         flush,
  input  fetch_entry_t load_entry,
  output fetch_entry_t entry,
  output logic         valid
);

  localparam fetch_entry_t EMPTY = '{instr: NOP_INSTR, pc_plus_4: '0};

  fetch_entry_t entry_q, entry_d;
  logic         valid_q, valid_d;

  // Next entry: flush beats load, load beats consume.
  always_comb begin
    entry_d = entry_q;
    valid_d = valid_q;
    if (flush) begin
      entry_d = EMPTY;
      valid_d = 1'b0;
    end else if (load) begin
      entry_d = load_entry;
      valid_d = 1'b1;
    end else if (consume) begin
      entry_d = EMPTY;
      valid_d = 1'b0;
    end
  end

  // Entry register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_q <= EMPTY;
      valid_q <= 1'b0;
    end else begin
      entry_q <= entry_d;
      valid_q <= valid_d;
    end
  end

  assign entry = entry_q;
  assign valid = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the PC, keeps one request in flight
// and parks each response in a one-entry buffer until decode takes it.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned        WIDTH_32  = FETCH_W,
  parameter logic [FETCH_W-1:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [FETCH_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                EN_F,
  input  logic                REDIRECT,
  input  logic [WIDTH_32-1:0] REDIRECT_PC,
  fetch_unit_if.master        mif,
  output logic [WIDTH_32-1:0] INSTRUCTION_F,
  output logic [WIDTH_32-1:0] PC_plus_4_F,
  output logic                FETCH_VALID_F
);

  fetch_state_e        state_q, state_d;
  logic [WIDTH_32-1:0] pc_q, pc_d;
  logic [WIDTH_32-1:0] pend_pc_q, pend_pc_d;

  logic         req_c;
  logic         buf_valid;
  logic         buf_load;
  fetch_entry_t buf_in;
  fetch_entry_t buf_out;

  // Request only when the buffer is free this edge, so responses never overflow it.
  always_comb begin
    req_c = rst_n && (state_q == REQ) && (!buf_valid || EN_F);
  end

  assign mif.IMEM_REQ  = req_c;
  assign mif.IMEM_ADDR = pc_q;

  // Next-state, PC advance and buffer load; a redirect overrides everything.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pend_pc_d = pend_pc_q;
    buf_load  = 1'b0;
    case (state_q)
      REQ: begin
        if (req_c && mif.IMEM_GNT) begin
          pc_d      = pc_q + PC_INC;
          pend_pc_d = pc_q;
          state_d   = REDIRECT ? KILL : WAIT;
        end
      end
      WAIT: begin
        if (mif.IMEM_RVALID) begin
          buf_load = !REDIRECT;
          state_d  = REQ;
        end else if (REDIRECT) begin
          state_d = KILL;
        end
      end
      KILL: begin
        // The stale response retires the kill even if another redirect lands
        // on the same edge; the PC already holds the newest target.
        if (mif.IMEM_RVALID) begin
          state_d = REQ;
        end
      end
      default: state_d = REQ;
    endcase
    if (REDIRECT) begin
      pc_d = REDIRECT_PC;
    end
  end

  // FSM, PC and pending-address registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= REQ;
      pc_q      <= RESET_PC;
      pend_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  // Response payload tagged with the address it was fetched from, plus 4.
  always_comb begin
    buf_in = '{instr: mif.IMEM_RDATA, pc_plus_4: pend_pc_q + PC_INC};
  end

  fetch_buffer #(
    .NOP_INSTR (NOP_INSTR)
  ) u_buffer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (buf_load),
    .consume    (EN_F && buf_valid),
    .flush      (REDIRECT),
    .load_entry (buf_in),
    .entry      (buf_out),
    .valid      (buf_valid)
  );

  assign INSTRUCTION_F = buf_out.instr;
  assign PC_plus_4_F   = buf_out.pc_plus_4;
  assign FETCH_VALID_F = buf_valid;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch front end that produces INSTRUCTION_F and PC_plus_4_F for the Fetch/Decode pipeline register.
- Owns the PC and issues one outstanding request at a time to a variable-latency instruction memory (req/gnt, rvalid handshake).
- Holds each fetched instruction in a one-entry buffer until the pipeline accepts it (EN_F).
- Handles branch/jump redirects by killing any in-flight fetch and restarting at the target.

Parameters:
WIDTH_32, 32, data/address width
RESET_PC, 32'h0000_0000, PC value after reset
NOP_INSTR, 32'h0000_0000, value driven on INSTRUCTION_F when no valid instruction is held

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
EN_F  input  1  hazard-unit advance; 1 = decode register captures the fetch outputs this edge
REDIRECT  input  1  resolved taken branch/jump, single-cycle pulse
REDIRECT_PC  input  32  target address, valid with REDIRECT
IMEM_REQ  output  1  fetch request
IMEM_ADDR  output  32  fetch address, valid with IMEM_REQ
IMEM_GNT  input  1  memory accepts the request this cycle; may be combinational
IMEM_RVALID  input  1  response data valid; earliest one cycle after the grant
IMEM_RDATA  input  32  response instruction
INSTRUCTION_F  output  32  buffered instruction, or NOP_INSTR when empty
PC_plus_4_F  output  32  address of the buffered instruction + 4, or 0 when empty
FETCH_VALID_F  output  1  buffer holds a valid instruction

Behaviour:
- Reset (async, rst_n=0):
  - state=REQ, PC_F=RESET_PC, buffer empty, kill cleared.
  - Outputs: IMEM_REQ=0 during reset, INSTRUCTION_F=NOP_INSTR, PC_plus_4_F=0, FETCH_VALID_F=0.
  - Reset mid-transaction abandons any outstanding fetch. IMEM_RVALID outside WAIT/KILL is ignored.
- States:
  - REQ: IMEM_REQ = !buf_valid | EN_F; IMEM_ADDR = PC_F.
    - On REQ & GNT: PC_F <= PC_F+4 (mod 2^32), latch the request address into pend_pc, go to WAIT.
  - WAIT: IMEM_REQ=0.
    - On RVALID: buffer <= {RDATA, pend_pc+4}, buf_valid <= 1, go to REQ.
  - KILL: IMEM_REQ=0.
    - On RVALID: discard the data, go to REQ.
- Buffer consume: at an edge with buf_valid & EN_F, buf_valid <= 0 unless refilled that same edge.
- A request is only issued when the buffer is empty or is being consumed that cycle, so a response always lands in an empty buffer (no overflow).
- EN_F=0: buffer and outputs hold. A request may already be outstanding.
- REDIRECT has priority over every other event:
  - PC_F <= REDIRECT_PC and buf_valid <= 0.
  - REQ without GNT: stay in REQ; IMEM_ADDR = REDIRECT_PC from the next cycle. The memory tolerates an address change on an ungranted request.
  - REQ with GNT in the same cycle: go to KILL (the granted fetch is stale).
  - WAIT without RVALID: go to KILL.
  - WAIT with RVALID in the same cycle: drop the data, go to REQ.
  - KILL: stay in KILL.
  - REDIRECT while EN_F=1 and buf_valid=1: the decode register still captures the current outputs that edge. Squashing that instruction is the hazard unit's CLR job.
- Output latency:
  - The response is visible on FETCH_VALID_F the cycle after IMEM_RVALID.
  - With zero-wait memory (combinational GNT, RVALID one cycle later), sustained throughput is one instruction per 2 cycles.
  - Redirect at edge N gives IMEM_ADDR=REDIRECT_PC at cycle N+1 if no fetch is outstanding.
- Downstream contract: when FETCH_VALID_F=0 and EN_F=1, the hazard unit asserts CLR on the decode register so a bubble enters.
- All outputs come from registers, except IMEM_REQ and IMEM_ADDR, which decode from state, buffer status, EN_F and PC_F.

Decomposition:
- Package fetch_pkg:
  - state enum {REQ, WAIT, KILL}
  - NOP_INSTR and RESET_PC defaults
  - PC_INC = 4
- Sub-module fetch_buffer: one-entry instruction/PC holding register with load, consume and flush inputs, and valid output.
- The FSM, PC register and kill logic stay in fetch_unit.

Test Plan:
- Reset release, GNT tied 1, RVALID one cycle later, EN_F=1 → IMEM_ADDR sequence 0x0, 0x4, 0x8; FETCH_VALID_F pulses, PC_plus_4_F = 0x4, 0x8, 0xC; INSTRUCTION_F equals RDATA.
- EN_F=0 for 5 cycles with buffer full → IMEM_REQ=0, outputs stable. EN_F returns to 1 → IMEM_REQ re-asserts the same cycle at the next PC.
- REDIRECT to 0x100 while in WAIT; late RVALID carries 0xDEADBEEF → data discarded, FETCH_VALID_F stays 0, next IMEM_ADDR=0x100.
- REDIRECT to 0x200 in the same cycle as REQ&GNT at 0x10 → state KILL; the 0x10 response is dropped; next grant at 0x200; PC_plus_4_F=0x204.
- GNT withheld 3 cycles, then PC_F=0xFFFF_FFFC fetched → address held stable until the grant; wrap gives PC_plus_4_F=0x0000_0000 and next address 0x0.
- rst_n low mid-WAIT → outputs cleared immediately (async); after release, a stray RVALID is ignored and fetch restarts at RESET_PC.
